// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch and decode stages.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/instruction_fetch.sv
// Multicycle instruction fetch: owns PC, old PC and IR, and issues one
// valid/ready request per fetch to instruction memory.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_update,
    input  logic [31:0] pc_next,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic        instr_valid,
    output logic        busy,
    output logic        misaligned,
    output logic        protocol_err
);

    fetch_state_t state_q, state_d;

    logic [XLEN-1:0] pc_q, old_pc_q, instr_q;
    logic            instr_valid_q, misaligned_q, protocol_err_q;
    logic            fetch_done;

    // A response only counts once the request handshake has completed.
    assign fetch_done = ((state_q == REQ) && imem_req_ready && imem_rsp_valid) ||
                        ((state_q == WAIT) && imem_rsp_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_req) state_d = REQ;
            end
            REQ: begin
                if (imem_req_ready) state_d = imem_rsp_valid ? IDLE : WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == REQ);
        busy           = (state_q != IDLE);
        imem_req_addr  = pc_q;
        instr          = instr_q;
        pc             = pc_q;
        old_pc         = old_pc_q;
        instr_valid    = instr_valid_q;
        misaligned     = misaligned_q;
        protocol_err   = protocol_err_q;
    end

    // Override in IDLE lands in pc_q at the same edge that enters REQ,
    // so the request address already reflects the branch target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            old_pc_q       <= RESET_PC;
            instr_q        <= NOP_INSTR;
            instr_valid_q  <= 1'b0;
            misaligned_q   <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (pc_update) begin
                    pc_q         <= {pc_next[31:2], 2'b00};
                    misaligned_q <= |pc_next[1:0];
                end
            end else begin
                if (pc_update) protocol_err_q <= 1'b1;
                if (fetch_done) begin
                    instr_q       <= imem_rsp_data;
                    old_pc_q      <= pc_q;
                    pc_q          <= pc_q + 32'd4;
                    instr_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule
